// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module  : muldiv_pkg
// Brief   : Shared op encodings and FSM state encoding for the mul/div unit.
// Config  : MULDIV_DIV_EN (see muldiv_unit) selects whether divide is built.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

  // Operation select as presented on w_op_2
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // Signed ops take magnitudes up front and fix the sign afterwards
  function automatic logic op_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic op_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage : muldiv_pkg

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
// Module  : muldiv_step
// Brief   : One iteration of the bit-serial datapath on the {hi,lo} pair.
//           Multiply: conditional add of the multiplicand into hi, then a
//           right shift of {carry,hi,lo}. Divide (only when MULDIV_DIV_EN is
//           defined): restoring step on magnitudes, quotient bits enter lo.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] mul_sum;

  // Shift-add: lo[0] is the current multiplier bit, carry lands in hi MSB
  always_comb begin
    mul_sum = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
  end

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   div_sh;
  logic [WIDTH+1:0] div_diff;
  logic             unused_div_msb;

  // Partial remainder is always below the divisor, so a non-negative trial
  // difference fits back into WIDTH bits; its bit WIDTH is always zero.
  assign unused_div_msb = div_diff[WIDTH];

  // Restoring divide step when dividing, otherwise the multiply shift
  always_comb begin
    div_sh   = {hi_i, lo_i[WIDTH-1]};
    div_diff = {1'b0, div_sh} - {2'b00, opnd_i};
    if (div_i) begin
      if (!div_diff[WIDTH+1]) begin
        hi_o = div_diff[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b1};
      end else begin
        hi_o = div_sh[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_o = mul_sum[WIDTH:1];
      lo_o = {mul_sum[0], lo_i[WIDTH-1:1]};
    end
  end
`else
  logic unused_div_sel;

  // No divider in this build; divide ops simply run the multiply path
  assign unused_div_sel = div_i;

  // Multiply shift only
  always_comb begin
    hi_o = mul_sum[WIDTH:1];
    lo_o = {mul_sum[0], lo_i[WIDTH-1:1]};
  end
`endif

endmodule : muldiv_step

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module  : muldiv_unit
// Brief   : Multi-cycle MIPS-style MULT/MULTU/DIV/DIVU unit with HI/LO.
//           IDLE -> CALC (WIDTH cycles) -> FIX (sign fix) -> DONE -> IDLE.
// Config  : MULDIV_DIV_EN defined   -> DIV/DIVU implemented.
//           MULDIV_DIV_EN undefined -> divider absent; DIV/DIVU finish with
//           multiply latency, leave HI/LO alone and raise w_div_zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             w_clock,
  input  logic             w_reset_n,
  input  logic             w_start,
  input  logic [1:0]       w_op_2,
  input  logic [WIDTH-1:0] w_input1_x,
  input  logic [WIDTH-1:0] w_input2_x,
  input  logic             w_mthi,
  input  logic             w_mtlo,
  input  logic             w_flush,
  output logic             w_busy,
  output logic             w_done,
  output logic [WIDTH-1:0] w_hi_x,
  output logic [WIDTH-1:0] w_lo_x,
  output logic             w_div_zero
);

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int CW = $clog2(WIDTH);

  md_state_e        state_q;
  md_op_e           op_q;
  logic [CW-1:0]    cnt_q;
  logic             neg1_q, neg2_q, dz_pend_q;
  logic [WIDTH-1:0] dvd_q, opnd_q, acc_hi_q, acc_lo_q, hi_q, lo_q;
  logic             busy_q, done_q, dz_q;

  md_op_e           op_in;
  logic             start_div, start_neg1, start_neg2;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod_neg;
  logic             cur_div;

  assign op_in    = md_op_e'(w_op_2);
  assign cur_div  = op_is_div(op_q);
  assign prod_neg = -{acc_hi_q, acc_lo_q};

  assign w_busy     = busy_q;
  assign w_done     = done_q;
  assign w_hi_x     = hi_q;
  assign w_lo_x     = lo_q;
  assign w_div_zero = dz_q;

  // Operand magnitudes and signs captured at launch
  always_comb begin
    start_div  = op_is_div(op_in);
    start_neg1 = op_is_signed(op_in) & w_input1_x[WIDTH-1];
    start_neg2 = op_is_signed(op_in) & w_input2_x[WIDTH-1];
    mag1       = start_neg1 ? -w_input1_x : w_input1_x;
    mag2       = start_neg2 ? -w_input2_x : w_input2_x;
  end

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .div_i (cur_div),
    .hi_i  (acc_hi_q),
    .lo_i  (acc_lo_q),
    .opnd_i(opnd_q),
    .hi_o  (step_hi),
    .lo_o  (step_lo)
  );

  // Sequencer, accumulators and architectural HI/LO with registered outputs
  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      state_q   <= ST_IDLE;
      op_q      <= MD_MULT;
      cnt_q     <= '0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      dz_pend_q <= 1'b0;
      dvd_q     <= '0;
      opnd_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      if (w_flush) begin
        // Abort wins over everything, including a same-cycle start
        state_q   <= ST_IDLE;
        busy_q    <= 1'b0;
        dz_pend_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (w_mthi) hi_q <= w_input1_x;
            if (w_mtlo) lo_q <= w_input1_x;
            if (w_start) begin
              op_q      <= op_in;
              dvd_q     <= w_input1_x;
              neg1_q    <= start_neg1;
              neg2_q    <= start_neg2;
              acc_hi_q  <= '0;
              // Divide iterates on the dividend, multiply on the multiplier
              acc_lo_q  <= start_div ? mag1 : mag2;
              opnd_q    <= start_div ? mag2 : mag1;
              cnt_q     <= CW'(WIDTH - 1);
              dz_pend_q <= 1'b0;
              busy_q    <= 1'b1;
              state_q   <= ST_CALC;
            end
          end
          ST_CALC: begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
            if (cnt_q == '0) state_q <= ST_FIX;
            else             cnt_q   <= cnt_q - CW'(1);
          end
          ST_FIX: begin
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
            if (!cur_div) begin
              if (neg1_q ^ neg2_q) {acc_hi_q, acc_lo_q} <= prod_neg;
            end else if (!DIV_EN) begin
              dz_pend_q <= 1'b1;
            end else if (opnd_q == '0) begin
              acc_hi_q  <= dvd_q;
              acc_lo_q  <= '1;
              dz_pend_q <= 1'b1;
            end else begin
              // Quotient truncates toward zero; remainder follows the dividend
              if (neg1_q ^ neg2_q) acc_lo_q <= -acc_lo_q;
              if (neg1_q)          acc_hi_q <= -acc_hi_q;
            end
          end
          ST_DONE: begin
            if (!(cur_div && !DIV_EN)) begin
              hi_q <= acc_hi_q;
              lo_q <= acc_lo_q;
            end
            done_q  <= 1'b1;
            dz_q    <= dz_pend_q;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule : muldiv_unit

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module  : tb_muldiv_unit
// Brief   : Self-checking bench for muldiv_unit (WIDTH=32) with an arithmetic
//           reference model; honours MULDIV_DIV_EN like the design.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_muldiv_unit;

  localparam int W = 32;
  localparam int LAT = W + 2;

  logic         w_clock = 1'b0;
  logic         w_reset_n = 1'b0;
  logic         w_start = 1'b0;
  logic [1:0]   w_op_2 = 2'b00;
  logic [W-1:0] w_input1_x = '0;
  logic [W-1:0] w_input2_x = '0;
  logic         w_mthi = 1'b0;
  logic         w_mtlo = 1'b0;
  logic         w_flush = 1'b0;
  logic         w_busy, w_done, w_div_zero;
  logic [W-1:0] w_hi_x, w_lo_x;

  int total = 0;
  int bad = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always #5 w_clock = ~w_clock;

  muldiv_unit #(.WIDTH(W)) dut (
    .w_clock   (w_clock),
    .w_reset_n (w_reset_n),
    .w_start   (w_start),
    .w_op_2    (w_op_2),
    .w_input1_x(w_input1_x),
    .w_input2_x(w_input2_x),
    .w_mthi    (w_mthi),
    .w_mtlo    (w_mtlo),
    .w_flush   (w_flush),
    .w_busy    (w_busy),
    .w_done    (w_done),
    .w_hi_x    (w_hi_x),
    .w_lo_x    (w_lo_x),
    .w_div_zero(w_div_zero)
  );

  // Reference: plain arithmetic on the architectural HI/LO
  function automatic void ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 inout logic [W-1:0] hi, inout logic [W-1:0] lo, output logic dz);
    logic [63:0] p;
    longint sa, sb;
    dz = 1'b0;
    case (op)
      2'b00: begin
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        hi = p[63:32]; lo = p[31:0];
      end
      2'b01: begin
        p = {32'b0, a} * {32'b0, b};
        hi = p[63:32]; lo = p[31:0];
      end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == '0) begin
          hi = a; lo = '1; dz = 1'b1;
        end else if (op == 2'b10) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          hi = W'(sa % sb);
          lo = W'(sa / sb);
        end else begin
          hi = a % b;
          lo = a / b;
        end
`else
        dz = 1'b1;
`endif
      end
    endcase
  endfunction

  // Launch one op and observe it for a fixed window after the launch edge
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int dcnt, output int dat, output logic [W-1:0] hi, output logic [W-1:0] lo,
                        output logic dz, output logic busy_ok);
    @(negedge w_clock);
    w_op_2 = op; w_input1_x = a; w_input2_x = b; w_start = 1'b1;
    @(negedge w_clock);
    w_start = 1'b0;
    busy_ok = (w_busy === 1'b1);
    dcnt = 0; dat = -1; hi = 'x; lo = 'x; dz = 1'bx;
    for (int k = 1; k <= LAT + 6; k++) begin
      @(negedge w_clock);
      if (k == LAT - 2 && w_busy !== 1'b1) busy_ok = 1'b0;
      if (k == LAT - 1 && w_busy !== 1'b0) busy_ok = 1'b0;
      if (w_done === 1'b1) begin
        dcnt++;
        if (dat < 0) begin
          dat = k; hi = w_hi_x; lo = w_lo_x; dz = w_div_zero;
        end
      end
    end
  endtask

  task automatic test_reset();
    int dc, da; logic [W-1:0] h, l; logic z, bo;
    w_reset_n = 1'b0;
    repeat (2) @(negedge w_clock);
    total++; if (w_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", w_busy); end
    total++; if (w_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", w_done); end
    total++; if (w_div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b exp=0", w_div_zero); end
    total++; if (w_hi_x !== '0) begin bad++; $display("FAIL reset_hi got=%h exp=0", w_hi_x); end
    total++; if (w_lo_x !== '0) begin bad++; $display("FAIL reset_lo got=%h exp=0", w_lo_x); end
    @(posedge w_clock); #2 w_reset_n = 1'b1;
    // First edge after release must accept the start
    run_op(2'b01, 32'd12345, 32'd678, dc, da, h, l, z, bo);
    ref_op(2'b01, 32'd12345, 32'd678, m_hi, m_lo, z);
    total++; if (da !== LAT) begin bad++; $display("FAIL first_op_latency got=%0d exp=%0d", da, LAT); end
    total++; if (l !== m_lo || h !== m_hi) begin bad++; $display("FAIL first_op_result got=%h_%h exp=%h_%h", h, l, m_hi, m_lo); end
  endtask

  task automatic test_directed();
    logic [1:0]   ops[8] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00, 2'b11, 2'b10};
    logic [W-1:0] as[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000, 32'd7, 32'h80000000, 32'hFFFFFFFF, 32'd5};
    logic [W-1:0] bs[8]  = '{32'd2, 32'd2, 32'd2, 32'hFFFFFFFF, 32'd0, 32'h80000000, 32'd3, 32'hFFFFFFFD};
    int dc, da; logic [W-1:0] h, l; logic z, ez, bo;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], as[i], bs[i], dc, da, h, l, z, bo);
      ref_op(ops[i], as[i], bs[i], m_hi, m_lo, ez);
      total++; if (h !== m_hi || l !== m_lo) begin bad++; $display("FAIL dir%0d_hilo got=%h_%h exp=%h_%h", i, h, l, m_hi, m_lo); end
      total++; if (z !== ez) begin bad++; $display("FAIL dir%0d_dz got=%b exp=%b", i, z, ez); end
      total++; if (dc !== 1 || da !== LAT) begin bad++; $display("FAIL dir%0d_done got cnt=%0d at=%0d exp cnt=1 at=%0d", i, dc, da, LAT); end
      total++; if (bo !== 1'b1) begin bad++; $display("FAIL dir%0d_busy got=%b exp=1", i, bo); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] corner[6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};
    int dc, da; logic [W-1:0] a, b, h, l; logic [1:0] op; logic z, ez, bo;
    for (int i = 0; i < 16; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      if (i % 5 == 4) b = $urandom_range(0, 9);
      run_op(op, a, b, dc, da, h, l, z, bo);
      ref_op(op, a, b, m_hi, m_lo, ez);
      total++;
      if (h !== m_hi || l !== m_lo || z !== ez || dc !== 1 || da !== LAT)
        begin bad++; $display("FAIL rnd%0d op=%0d a=%h b=%h got=%h_%h dz=%b at=%0d exp=%h_%h dz=%b at=%0d",
                              i, op, a, b, h, l, z, da, m_hi, m_lo, ez, LAT); end
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [63:0] p;
    @(negedge w_clock);
    w_input1_x = 32'h1234; w_mthi = 1'b1;
    @(negedge w_clock);
    w_mthi = 1'b0; m_hi = 32'h1234;
    total++; if (w_hi_x !== 32'h1234 || w_lo_x !== m_lo) begin bad++; $display("FAIL mthi got=%h_%h exp=%h_%h", w_hi_x, w_lo_x, m_hi, m_lo); end
    w_input1_x = 32'hCAFE0001; w_mtlo = 1'b1;
    @(negedge w_clock);
    w_mtlo = 1'b0; m_lo = 32'hCAFE0001;
    total++; if (w_lo_x !== m_lo || w_hi_x !== m_hi) begin bad++; $display("FAIL mtlo got=%h_%h exp=%h_%h", w_hi_x, w_lo_x, m_hi, m_lo); end
    // Start with MTLO in the same cycle: write lands now, result later
    w_op_2 = 2'b01; w_input1_x = 32'h00010003; w_input2_x = 32'h00000105; w_mtlo = 1'b1; w_start = 1'b1;
    @(negedge w_clock);
    w_mtlo = 1'b0; w_start = 1'b0;
    total++; if (w_lo_x !== 32'h00010003) begin bad++; $display("FAIL mtlo_start_write got=%h exp=00010003", w_lo_x); end
    repeat (LAT) @(negedge w_clock);
    p = 64'h00010003 * 64'h00000105;
    m_hi = p[63:32]; m_lo = p[31:0];
    total++; if (w_done !== 1'b1 || w_lo_x !== m_lo || w_hi_x !== m_hi) begin bad++; $display("FAIL mtlo_start_result got=%h_%h done=%b exp=%h_%h done=1", w_hi_x, w_lo_x, w_done, m_hi, m_lo); end
  endtask

  task automatic test_ignore_start();
    int dc; logic [W-1:0] h, l; logic z;
    @(negedge w_clock);
    w_op_2 = 2'b00; w_input1_x = 32'hFFFF0000; w_input2_x = 32'h00000123; w_start = 1'b1;
    @(negedge w_clock);
    w_start = 1'b0;
    dc = 0; h = 'x; l = 'x;
    for (int k = 1; k <= LAT + 8; k++) begin
      if (k == 5) begin w_op_2 = 2'b01; w_input1_x = 32'h11111111; w_input2_x = 32'h3; w_start = 1'b1; end
      @(negedge w_clock);
      w_start = 1'b0;
      if (w_done === 1'b1) begin dc++; h = w_hi_x; l = w_lo_x; end
    end
    ref_op(2'b00, 32'hFFFF0000, 32'h00000123, m_hi, m_lo, z);
    total++; if (dc !== 1) begin bad++; $display("FAIL ignore_start_dones got=%0d exp=1", dc); end
    total++; if (h !== m_hi || l !== m_lo) begin bad++; $display("FAIL ignore_start_result got=%h_%h exp=%h_%h", h, l, m_hi, m_lo); end
  endtask

  task automatic test_flush();
    int dc;
    @(negedge w_clock);
    w_op_2 = 2'b01; w_input1_x = 32'h00ABCDEF; w_input2_x = 32'h00001000; w_start = 1'b1;
    @(negedge w_clock);
    w_start = 1'b0;
    repeat (9) @(negedge w_clock);
    w_flush = 1'b1;
    @(negedge w_clock);
    w_flush = 1'b0;
    total++; if (w_busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", w_busy); end
    // Flush together with start in IDLE: start must lose
    w_start = 1'b1; w_flush = 1'b1;
    @(negedge w_clock);
    w_start = 1'b0; w_flush = 1'b0;
    total++; if (w_busy !== 1'b0) begin bad++; $display("FAIL flush_over_start got=%b exp=0", w_busy); end
    dc = 0;
    for (int k = 0; k < LAT + 4; k++) begin
      @(negedge w_clock);
      if (w_done === 1'b1) dc++;
    end
    total++; if (dc !== 0) begin bad++; $display("FAIL flush_no_done got=%0d exp=0", dc); end
    total++; if (w_hi_x !== m_hi || w_lo_x !== m_lo) begin bad++; $display("FAIL flush_hilo got=%h_%h exp=%h_%h", w_hi_x, w_lo_x, m_hi, m_lo); end
  endtask

  task automatic test_reset_mid();
    int dc, da; logic [W-1:0] h, l; logic z, bo;
    @(negedge w_clock);
    w_op_2 = 2'b00; w_input1_x = 32'h12345678; w_input2_x = 32'h9ABCDEF0; w_start = 1'b1;
    @(negedge w_clock);
    w_start = 1'b0;
    repeat (9) @(negedge w_clock);
    w_reset_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    total++; if (w_busy !== 1'b0 || w_done !== 1'b0) begin bad++; $display("FAIL midreset_ctrl got busy=%b done=%b exp=0/0", w_busy, w_done); end
    total++; if (w_hi_x !== '0 || w_lo_x !== '0) begin bad++; $display("FAIL midreset_hilo got=%h_%h exp=0_0", w_hi_x, w_lo_x); end
    @(posedge w_clock); #2 w_reset_n = 1'b1;
    dc = 0;
    for (int k = 0; k < LAT + 4; k++) begin
      @(negedge w_clock);
      if (w_done === 1'b1) dc++;
    end
    total++; if (dc !== 0) begin bad++; $display("FAIL midreset_no_done got=%0d exp=0", dc); end
    run_op(2'b00, 32'hFFFFFFFF, 32'h2, dc, da, h, l, z, bo);
    ref_op(2'b00, 32'hFFFFFFFF, 32'h2, m_hi, m_lo, z);
    total++; if (h !== m_hi || l !== m_lo || da !== LAT) begin bad++; $display("FAIL post_reset_op got=%h_%h at=%0d exp=%h_%h at=%0d", h, l, da, m_hi, m_lo, LAT); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_mthi_mtlo();
    test_ignore_start();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_muldiv_unit

`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand, HI and LO width (even, >=4).
REQ-002 The block SHALL have port w_clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port w_reset_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port w_start  input  1  request to launch the operation on w_op_2.
REQ-005 The block SHALL have port w_op_2  input  2  op select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The block SHALL have port w_input1_x  input  WIDTH  rs operand: multiplicand or dividend.
REQ-007 The block SHALL have port w_input2_x  input  WIDTH  rt operand: multiplier or divisor.
REQ-008 The block SHALL have port w_mthi  input  1  write w_input1_x into HI.
REQ-009 The block SHALL have port w_mtlo  input  1  write w_input1_x into LO.
REQ-010 The block SHALL have port w_flush  input  1  synchronous abort of the operation in flight.
REQ-011 The block SHALL have port w_busy  output  1  high while an operation is in flight.
REQ-012 The block SHALL have port w_done  output  1  one-cycle pulse when HI/LO take a new result.
REQ-013 The block SHALL have port w_hi_x  output  WIDTH  HI register (MFHI source).
REQ-014 The block SHALL have port w_lo_x  output  WIDTH  LO register (MFLO source).
REQ-015 The block SHALL have port w_div_zero  output  1  pulses with w_done for a divide with divisor 0.

Function
REQ-016 FSM SHALL have states IDLE, CALC, FIX, DONE; w_busy SHALL be high in CALC and FIX.
REQ-017 In IDLE with w_start=1, operands and op SHALL be latched and the FSM SHALL enter CALC with step counter=WIDTH-1.
REQ-018 CALC SHALL process one bit per cycle (shift-add multiply, restoring divide on magnitudes) and enter FIX after WIDTH cycles.
REQ-019 FIX SHALL apply sign correction for MULT/DIV in one cycle, then enter DONE.
REQ-020 In DONE HI/LO SHALL update and w_done SHALL pulse; the FSM SHALL return to IDLE next cycle. Start on edge 0 -> w_done high for the cycle after edge WIDTH+2.
REQ-021 Multiply results SHALL be HI = product[2*WIDTH-1:WIDTH], LO = product[WIDTH-1:0].
REQ-022 Divide results SHALL be LO = quotient truncated toward zero, HI = remainder with the dividend's sign.
REQ-023 A divisor of 0 SHALL give HI=dividend, LO=all ones, w_div_zero=1; latency is unchanged.
REQ-024 DIV of most-negative by -1 SHALL give LO=most-negative and HI=0, with no flag.
REQ-025 w_start while not in IDLE SHALL be ignored.
REQ-026 w_mthi/w_mtlo SHALL write in IDLE only and SHALL be ignored otherwise; w_start and w_mthi/w_mtlo in the same IDLE cycle SHALL apply the write, after which the result overwrites it.
REQ-027 w_flush SHALL force IDLE on the next edge from any state, with HI/LO unchanged and no w_done; it SHALL take precedence over w_start.

Reset
REQ-028 With w_reset_n low, the FSM SHALL be in IDLE and w_busy, w_done, w_div_zero, HI, LO and all internal accumulators SHALL be 0; this SHALL take effect immediately, including mid-operation.
REQ-029 After reset is released, the first rising edge SHALL accept w_start.

Configuration
REQ-030 Macro MULDIV_DIV_EN defined: DIV/DIVU SHALL be implemented as above.
REQ-031 Macro MULDIV_DIV_EN undefined: the divider SHALL be absent; DIV/DIVU SHALL complete with MULT latency, leave HI/LO unchanged, and pulse w_div_zero with w_done as an illegal-op flag.

Structure
REQ-032 Shared package muldiv_pkg SHALL hold the op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU) and the FSM state encoding.
REQ-033 The per-bit add/subtract-and-shift datapath SHALL be sub-module muldiv_step; muldiv_unit SHALL own the FSM, counter, sign handling and HI/LO.

Verification (WIDTH=32)
REQ-034 MULT 0xFFFFFFFF x 0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE, w_done in the cycle after edge 34.
REQ-035 MULTU 0xFFFFFFFF x 0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-036 DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-037 DIVU 7 / 0 -> HI=7, LO=0xFFFFFFFF, w_div_zero=1 with w_done.
REQ-038 A second w_start at cycle 5 of a MULT SHALL be ignored (one w_done only); w_flush at cycle 10 -> w_busy=0 next cycle, HI/LO unchanged, no w_done.
REQ-039 w_reset_n low at CALC cycle 10 -> immediately w_busy=0, HI=LO=0, no w_done; MTHI 0x1234 in IDLE -> w_hi_x=0x1234 next cycle.
